// File: rtl/icache_refill_ctrl.sv
// Instruction-cache miss sequencer: stalls fetch on a miss, pulls the line over
// a req/ack handshake, writes it into the cache and replays any redirect held meanwhile.
module icache_refill_ctrl #(
  parameter int ADDR_W  = 16,
  parameter int LINE_W  = 64,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] fetch_addr,
  input  logic              cache_hit,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_target,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [LINE_W-1:0] mem_data,
  output logic              fill_we,
  output logic [ADDR_W-1:0] fill_addr,
  output logic [LINE_W-1:0] fill_data,
  output logic              stall,
  output logic              pc_load,
  output logic [ADDR_W-1:0] pc_load_addr,
  output logic [CNT_W-1:0]  miss_count,
  output logic              timeout_err
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_FILL, S_RESUME, S_ERR} state_t;

  localparam logic [7:0]        TIMER_LAST = 8'(TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] LINE_MASK  = {{(ADDR_W-2){1'b1}}, 2'b00};
  localparam logic [CNT_W-1:0]  CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t            state_q, state_d;
  logic [7:0]        timer_q, timer_d;
  logic              pend_q, pend_d;
  logic [ADDR_W-1:0] pend_target_q, pend_target_d;
  logic [ADDR_W-1:0] miss_addr_q, miss_addr_d;
  logic [LINE_W-1:0] line_buf_q, line_buf_d;
  logic [CNT_W-1:0]  miss_count_q, miss_count_d;
  logic              timeout_err_q, timeout_err_d;
  logic              mem_req_q, mem_req_d;
  logic              fill_we_q, fill_we_d;

  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    pend_d        = pend_q;
    pend_target_d = pend_target_q;
    miss_addr_d   = miss_addr_q;
    line_buf_d    = line_buf_q;
    miss_count_d  = miss_count_q;
    timeout_err_d = timeout_err_q;
    mem_req_d     = mem_req_q;
    fill_we_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!cache_hit) begin
          state_d     = S_REQ;
          timer_d     = 8'd0;
          mem_req_d   = 1'b1;
          miss_addr_d = fetch_addr & LINE_MASK;
          if (miss_count_q != '1) miss_count_d = miss_count_q + CNT_ONE;
        end
      end
      S_REQ: begin
        timer_d = timer_q + 8'd1;
        // An ack on the last permitted cycle still completes the refill.
        if (mem_ack) begin
          line_buf_d = mem_data;
          state_d    = S_FILL;
          mem_req_d  = 1'b0;
          fill_we_d  = 1'b1;
        end else if (timer_q == TIMER_LAST) begin
          state_d       = S_ERR;
          mem_req_d     = 1'b0;
          timeout_err_d = 1'b1;
        end
      end
      S_FILL:   state_d = S_RESUME;
      S_RESUME: begin
        pend_d  = 1'b0;
        state_d = S_IDLE;
      end
      S_ERR:    state_d = S_ERR;
      default:  state_d = S_IDLE;
    endcase

    // In IDLE the PC mux takes the redirect itself; only hold it while stalled.
    if (redirect && (state_q == S_REQ || state_q == S_FILL || state_q == S_ERR)) begin
      pend_d        = 1'b1;
      pend_target_d = redirect_target;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      timer_q       <= '0;
      pend_q        <= 1'b0;
      pend_target_q <= '0;
      miss_addr_q   <= '0;
      line_buf_q    <= '0;
      miss_count_q  <= '0;
      timeout_err_q <= 1'b0;
      mem_req_q     <= 1'b0;
      fill_we_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      pend_q        <= pend_d;
      pend_target_q <= pend_target_d;
      miss_addr_q   <= miss_addr_d;
      line_buf_q    <= line_buf_d;
      miss_count_q  <= miss_count_d;
      timeout_err_q <= timeout_err_d;
      mem_req_q     <= mem_req_d;
      fill_we_q     <= fill_we_d;
    end
  end

  // The replay uses this cycle's redirect so the newest branch target wins.
  assign stall        = (state_q != S_IDLE) || !cache_hit;
  assign pc_load      = (state_q == S_RESUME) && (pend_q || redirect);
  assign pc_load_addr = (state_q == S_RESUME) ? (redirect ? redirect_target : pend_target_q) : '0;
  assign mem_req      = mem_req_q;
  assign mem_addr     = miss_addr_q;
  assign fill_we      = fill_we_q;
  assign fill_addr    = miss_addr_q;
  assign fill_data    = line_buf_q;
  assign miss_count   = miss_count_q;
  assign timeout_err  = timeout_err_q;

endmodule

// File: doc/icache_refill_ctrl.md
Name: icache_refill_ctrl

Overview:
Miss-handling sequencer for the fetch stage. It watches the instruction cache hit signal. On a miss it stalls the PC, fetches the 64-bit line from instruction memory over a req/ack handshake, and writes the line into the cache. A branch redirect that arrives during a refill is held and replayed into the PC when the refill completes.

Parameters:
ADDR_W, 16, instruction address width (word-addressed, 16-bit instructions)
LINE_W, 64, cache line width (4 instructions per line)
TIMEOUT, 255, max REQ cycles without mem_ack before error (1..255)
CNT_W, 16, miss counter width

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
fetch_addr  in  ADDR_W  current PC output
cache_hit  in  1  cache hit for fetch_addr, same cycle
redirect  in  1  branch taken (PC_src)
redirect_target  in  ADDR_W  branch target
mem_req  out  1  line request to instruction memory
mem_addr  out  ADDR_W  line-aligned request address
mem_ack  in  1  memory data valid / request accepted
mem_data  in  LINE_W  line data, valid when mem_ack=1
fill_we  out  1  cache line write strobe
fill_addr  out  ADDR_W  line-aligned fill address
fill_data  out  LINE_W  line to write
stall  out  1  hold PC and fetch outputs
pc_load  out  1  force PC to pc_load_addr this cycle
pc_load_addr  out  ADDR_W  replayed redirect target
miss_count  out  CNT_W  saturating miss counter
timeout_err  out  1  sticky memory timeout flag

Behaviour:
- Reset (sync, rst=1 at an edge): state=IDLE, timer=0, pend=0, pend_target=0, miss_count=0, timeout_err=0, line_buf=0.
- Reset values of outputs: mem_req=0, fill_we=0, pc_load=0, mem_addr=0, fill_addr=0, fill_data=0, pc_load_addr=0.
- Reset during any state aborts the refill. No fill write occurs. mem_req drops after the reset edge.
- stall is combinational: 1 when state!=IDLE, or when state==IDLE and cache_hit==0. Otherwise 0.
- miss_addr is registered on the IDLE->REQ transition as {fetch_addr[ADDR_W-1:2], 2'b00}.
- mem_addr and fill_addr both drive miss_addr.
- States:
  - IDLE: if cache_hit=0, go to REQ and increment miss_count (saturate at all-ones). Otherwise stay.
  - REQ: mem_req=1, timer increments each cycle starting from 0 at entry.
    - mem_ack=1: capture mem_data into line_buf, go to FILL.
    - else if timer==TIMEOUT-1: go to ERR.
    - mem_ack and timeout in the same cycle: ack wins.
  - FILL: fill_we=1 for exactly one cycle, fill_data=line_buf. Go to RESUME.
  - RESUME: one cycle, stall=1.
    - pc_load = pend | redirect.
    - pc_load_addr = redirect ? redirect_target : pend_target (the newer redirect wins).
    - Clear pend. Go to IDLE.
  - ERR: timeout_err=1 (sticky), mem_req=0, stall=1. Exit only via rst.
- Redirect capture: in REQ, FILL, ERR, if redirect=1 then pend<=1 and pend_target<=redirect_target. The latest redirect overwrites. In IDLE, redirect is ignored because the PC mux handles it directly.
- mem_req stays asserted from REQ entry until the cycle of mem_ack inclusive. Memory must not ack when mem_req=0; such an ack is ignored.
- Miss penalty with ack on the first REQ cycle is 4 stall cycles: IDLE-miss, REQ, FILL, RESUME. With ack on REQ cycle L it is 3+L.
- After RESUME the block returns to IDLE. If the next lookup still misses (e.g. redirected to another line), a new miss starts immediately with no idle gap required.
- A refill is never aborted by redirect; the fetched line is still written.

Test Plan:
- Hit stream: cache_hit=1 for 20 cycles, fetch_addr incrementing -> stall=0, mem_req=0, miss_count=0.
- Single miss, immediate ack:
  - Stimulus: fetch_addr=0x0013, cache_hit=0, mem_ack=1 on first REQ cycle with mem_data=0x1111_2222_3333_4444.
  - Response: mem_addr=0x0010; fill_we one cycle with fill_addr=0x0010 and that data; stall high exactly 4 cycles; miss_count=1.
- Redirect during wait:
  - Stimulus: miss at 0x0040, ack after 5 REQ cycles, redirect=1 target 0x0100 on REQ cycle 2, then target 0x0200 on FILL.
  - Response: fill still at 0x0040; RESUME pc_load=1, pc_load_addr=0x0200; pend cleared.
- Timeout:
  - Stimulus: miss with mem_ack held 0.
  - Response: after 255 REQ cycles the block enters ERR; timeout_err=1, mem_req=0, stall=1 held. Then rst=1 -> all outputs return to reset values.
  - Also cover ack exactly on REQ cycle 255 -> normal FILL, no error.
- Reset mid-refill: rst=1 during REQ -> no fill_we, mem_req=0 next cycle, miss_count=0.
- Saturation: force 65536 misses -> miss_count holds 0xFFFF.
